// File: rtl/load_store_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-memory port
// of load_store_unit. The slave modport is the LSU's view; the master modport
// is the environment's view (pipeline driving requests plus the data memory).
interface load_store_unit_if;
  // Pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Pipeline response and stall
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        busy;
  // Word-addressed data memory
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed
// data memory. Sub-word stores are read-modify-write; loads are extended.
// Optional feature macro: LSU_BOUNDS_CHECK_EN -- when defined, word indices
// at or beyond MEM_WORDS are rejected with error code 11 and never reach memory.
module load_store_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_RANGE    = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      r_state;
  state_e      w_next_state;

  // Request fields latched on acceptance
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_we;
  logic [1:0]  r_err;
  // Word captured from memory in RD
  logic [31:0] r_word;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic [1:0]  w_req_err;

  // Select the addressed byte/halfword lane and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_BU:   return {24'h000000, b};
      F3_HU:   return {16'h0000, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed lane of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00:   m[{off, 3'b000} +: 8]      = wdata[7:0];
      2'b01:   m[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: m                          = wdata;
    endcase
    return m;
  endfunction

  assign w_accept      = bus.req_valid && (r_state == S_IDLE);
  assign bus.mem_addr  = {2'b00, r_addr[31:2]};

  // Classify the incoming request; illegal beats misaligned beats out-of-range.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
    w_illegal      = 1'b0;
    w_misaligned   = 1'b0;
    w_out_of_range = 1'b0;
    w_req_err      = ERR_OK;

    if (bus.req_we)
      w_illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W});
    else
      w_illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});

    case (bus.req_funct3[1:0])
      2'b01:   w_misaligned = bus.req_addr[0];
      2'b10:   w_misaligned = |bus.req_addr[1:0];
      default: w_misaligned = 1'b0;
    endcase

    w_out_of_range = BOUNDS_EN && ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS));

    if (w_illegal)           w_req_err = ERR_ILLEGAL;
    else if (w_misaligned)   w_req_err = ERR_MISALIGN;
    else if (w_out_of_range) w_req_err = ERR_RANGE;
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode and all handshake/memory outputs.
  always_comb begin
    w_next_state   = r_state;
    bus.req_ready  = 1'b0;
    bus.busy       = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_err   = ERR_OK;
    bus.resp_rdata = 32'h0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = 32'h0;

    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.busy      = 1'b0;
        if (w_accept) begin
          if (w_req_err != ERR_OK)                       w_next_state = S_DONE;
          else if (bus.req_we && bus.req_funct3 == F3_W) w_next_state = S_WR;
          else                                           w_next_state = S_RD;
        end
      end
      S_RD: begin
        // Sub-word stores still need their write beat after the read.
        w_next_state = r_we ? S_WR : S_DONE;
      end
      S_WR: begin
        // Gated with rst so a reset landing on this beat drops the write.
        bus.mem_we    = !rst;
        bus.mem_wdata = store_merge(r_word, r_wdata, r_funct3[1:0], r_addr[1:0]);
        w_next_state  = S_DONE;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = r_err;
        if (!r_we && r_err == ERR_OK)
          bus.resp_rdata = load_extend(r_word, r_funct3, r_addr[1:0]);
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the request on acceptance and capture the memory word in RD.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_funct3 <= 3'b000;
      r_we     <= 1'b0;
      r_err    <= ERR_OK;
      r_word   <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
        r_funct3 <= bus.req_funct3;
        r_we     <= bus.req_we;
        r_err    <= w_req_err;
      end
      if (r_state == S_RD)
        r_word <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by
// randomized requests, all checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory attached to the DUT, plus a preload port for the bench.
  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  logic        pl_en;
  logic [9:0]  pl_idx;
  logic [31:0] pl_val;

  assign bus.mem_rdata = mem[bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (pl_en)           mem[pl_idx] <= pl_val;
    else if (bus.mem_we) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pl_en  = 1'b1;
    pl_idx = 10'(idx);
    pl_val = val;
    ref_mem[idx] = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Error code from the access rules: legality, then natural alignment, then range.
  function automatic logic [1:0] model_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] addr);
    bit legal;
    int size;
    if (we) legal = (f3 == 0 || f3 == 1 || f3 == 2);
    else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!legal) return 2'b10;
    size = 1 << f3[1:0];
    if (addr % size != 0) return 2'b01;
    if (BOUNDS_EN && (addr / 4) >= 1024) return 2'b11;
    return 2'b00;
  endfunction

  // One complete request from IDLE back to IDLE, checked against the model.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [1:0]      e_err;
    logic [31:0]     e_rd;
    logic [31:0]     word;
    int              e_lat, e_wecnt, size, off, idx;
    longint unsigned mask;
    int              lat, we_cnt, we_at;
    logic [31:0]     got_rd;
    logic [1:0]      got_err;

    idx   = int'(addr[11:2]);
    word  = ref_mem[idx];
    e_err = model_err(we, f3, addr);
    size  = 1 << f3[1:0];
    off   = int'(addr % 4);
    mask  = (64'd1 << (8 * size)) - 1;
    e_rd  = 32'h0;
    e_wecnt = 0;
    if (e_err != 2'b00) begin
      e_lat = 1;
    end else if (we) begin
      e_wecnt = 1;
      e_lat   = (size == 4) ? 2 : 3;
      ref_mem[idx] = (word & ~32'(mask << (8 * off))) | 32'((64'(wd) & mask) << (8 * off));
    end else begin
      e_lat = 2;
      e_rd  = 32'((64'(word >> (8 * off))) & mask);
      if (!f3[2] && size < 4 && e_rd[8 * size - 1]) e_rd = e_rd | ~32'(mask);
    end

    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    lat = 0; we_cnt = 0; we_at = 0; got_rd = 32'h0; got_err = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      if (bus.mem_we) begin
        we_cnt++;
        we_at = k;
        check({tag, "_waddr"}, bus.mem_addr, {2'b00, addr[31:2]});
      end
      if (bus.resp_valid) begin
        lat     = k;
        got_rd  = bus.resp_rdata;
        got_err = bus.resp_err;
        break;
      end
      @(posedge clk); #1;
    end

    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_err"}, 32'(got_err), 32'(e_err));
    check({tag, "_rdata"}, got_rd, e_rd);
    check({tag, "_we_cnt"}, 32'(we_cnt), 32'(e_wecnt));
    if (e_wecnt != 0) check({tag, "_we_cycle"}, 32'(we_at), 32'(e_lat - 1));

    @(posedge clk); #1;
    check({tag, "_idle"}, {30'h0, bus.busy, bus.resp_valid}, 32'h0);
    check({tag, "_mem"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic        rwe;
    logic [31:0] raddr;
    int          sel;

    total = 0;
    bad   = 0;
    pl_en = 1'b0;
    pl_idx = 10'h0;
    pl_val = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) preload(i, 32'h9E3779B1 * (i + 3));
    preload(1023, 32'hC0DEF00D);

    // Directed loads
    preload(7, 32'h00000020);
    do_req("lw_1c", 1'b0, 3'b010, 32'h1C, 32'h0);
    preload(7, 32'h80FF1234);
    do_req("lb_1f",  1'b0, 3'b000, 32'h1F, 32'h0);
    check("lb_1f_const", ref_mem[7], 32'h80FF1234);
    do_req("lbu_1f", 1'b0, 3'b100, 32'h1F, 32'h0);
    do_req("lh_1e",  1'b0, 3'b001, 32'h1E, 32'h0);
    do_req("lhu_1c", 1'b0, 3'b101, 32'h1C, 32'h0);

    // Directed stores
    preload(7, 32'h11223344);
    do_req("sb_1d", 1'b1, 3'b000, 32'h1D, 32'h000000AB);
    check("sb_1d_word", mem[7], 32'h1122AB44);
    do_req("sh_1e", 1'b1, 3'b001, 32'h1E, 32'h1234BEEF);
    do_req("sw_1c", 1'b1, 3'b010, 32'h1C, 32'hDEADBEEF);
    check("sw_1c_word", mem[7], 32'hDEADBEEF);

    // Errors
    do_req("lw_mis",     1'b0, 3'b010, 32'h1E, 32'h0);
    do_req("ld_f3_011",  1'b0, 3'b011, 32'h1C, 32'h0);
    do_req("sh_mis",     1'b1, 3'b001, 32'h1F, 32'h5555);
    do_req("st_ill_mis", 1'b1, 3'b101, 32'h1F, 32'h5555);
    do_req("lhu_mis",    1'b0, 3'b101, 32'h1D, 32'h0);

    // Reset during the write beat of a read-modify-write store
    preload(7, 32'h11223344);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h1C;
    bus.req_wdata  = 32'h0000BEEF;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstwr_in_wr", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwr_we_gated", 32'(bus.mem_we), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstwr_busy", 32'(bus.busy), 32'd0);
    check("rstwr_ready", 32'(bus.req_ready), 32'd1);
    check("rstwr_no_resp", 32'(bus.resp_valid), 32'd0);
    check("rstwr_word", mem[7], 32'h11223344);
    @(posedge clk); #1;
    check("rstwr_no_resp2", 32'(bus.resp_valid), 32'd0);

    // Back-to-back: req_valid held high across two loads
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h1C;
    @(posedge clk); #1;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("b2b_busy_%0d", k), 32'(bus.busy), (k == 3) ? 32'd0 : 32'd1);
      check($sformatf("b2b_valid_%0d", k), 32'(bus.resp_valid), (k == 2 || k == 5) ? 32'd1 : 32'd0);
      if (k == 2 || k == 5) check($sformatf("b2b_rdata_%0d", k), bus.resp_rdata, ref_mem[7]);
      if (k == 4) bus.req_valid = 1'b0;
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("b2b_idle", 32'(bus.busy), 32'd0);

    // Range boundary: last word is valid, first word past the end is not
    do_req("lw_ffc",  1'b0, 3'b010, 32'h00000FFC, 32'h0);
    do_req("lw_1000", 1'b0, 3'b010, 32'h00001000, 32'h0);

    // Randomized traffic over a small window of words
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) begin
        rwe = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 4))
          0: rf3 = 3'b000;
          1: rf3 = 3'b001;
          2: rf3 = 3'b010;
          3: rf3 = rwe ? 3'b000 : 3'b100;
          default: rf3 = rwe ? 3'b001 : 3'b101;
        endcase
        raddr = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
        if (rf3[1:0] == 2'b01) raddr[1] = 1'($urandom_range(0, 1));
        if (rf3[1:0] == 2'b00) raddr[1:0] = 2'($urandom_range(0, 3));
      end else begin
        rwe   = 1'($urandom_range(0, 1));
        rf3   = 3'($urandom_range(0, 7));
        raddr = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end
      do_req($sformatf("rnd%0d", n), rwe, rf3, raddr, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
